cond_check_pipe: RTL

- Multi-lane successor to the single-lane ARM condition evaluator.
- Owns the architectural NZCV status register and applies S-bit flag updates from EX.
- Evaluates the 4-bit condition field for LANES instructions per cycle, with optional same-cycle flag bypass and an optional output pipeline stage.
- Provides a DEPTH-entry flag save stack for exception entry and return; sits between decode/issue and EX/writeback.

---
 rtl/cond_check_pipe.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cond_check_pipe.sv
// Multi-lane ARM condition evaluator with the NZCV status register and a flag save stack.
// Optional same-cycle flag bypass and an optional registered output stage.
module cond_check_pipe #(
    parameter int LANES  = 2,
    parameter int PIPE   = 1,
    parameter int BYPASS = 1,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 upd_en,
    input  logic [3:0]           upd_flags,
    input  logic [4*LANES-1:0]   cond,
    input  logic [LANES-1:0]     in_valid,
    input  logic                 flush,
    input  logic                 push,
    input  logic                 pop,
    output logic [3:0]           status_out,
    output logic [LANES-1:0]     cond_pass,
    output logic [LANES-1:0]     out_valid,
    output logic                 stack_full,
    output logic                 stack_empty,
    output logic                 stack_err
);

    localparam int IDXW = $clog2(DEPTH);
    localparam int SPW  = IDXW + 1;

    logic [3:0]       status;
    logic [3:0]       stack [DEPTH];
    logic [SPW-1:0]   sp;
    logic [SPW-1:0]   spDec;
    logic [IDXW-1:0]  topIdx;
    logic [IDXW-1:0]  pushIdx;
    logic             legalPush;
    logic             legalPop;
    logic [3:0]       evalFlags;
    logic [LANES-1:0] pass;

    function automatic logic evalCond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'b0000: evalCond = z;
            4'b0001: evalCond = !z;
            4'b0010: evalCond = cy;
            4'b0011: evalCond = !cy;
            4'b0100: evalCond = n;
            4'b0101: evalCond = !n;
            4'b0110: evalCond = v;
            4'b0111: evalCond = !v;
            4'b1000: evalCond = cy && !z;
            4'b1001: evalCond = !cy || z;
            4'b1010: evalCond = (n == v);
            4'b1011: evalCond = (n != v);
            4'b1100: evalCond = !z && (n == v);
            4'b1101: evalCond = z || (n != v);
            4'b1110: evalCond = 1'b1;
            default: evalCond = 1'b0;
        endcase
    endfunction

    assign stack_full  = (sp == SPW'(DEPTH));
    assign stack_empty = (sp == '0);
    assign spDec       = sp - SPW'(1);
    assign topIdx      = spDec[IDXW-1:0];
    assign pushIdx     = sp[IDXW-1:0];
    assign legalPush   = push && !pop && !stack_full;
    assign legalPop    = pop && !push && !stack_empty;
    assign status_out  = status;

    // A pop restoring status this cycle is not visible to evaluation; only upd_flags bypass.
    assign evalFlags = (BYPASS != 0 && upd_en) ? upd_flags : status;

    always_comb begin
        pass = '0;
        for (int i = 0; i < LANES; i++) begin
            pass[i] = in_valid[i] && evalCond(cond[4*i +: 4], evalFlags);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status    <= '0;
            sp        <= '0;
            stack_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            if (legalPop) begin
                status <= stack[topIdx];
                sp     <= spDec;
            end else if (upd_en) begin
                status <= upd_flags;
            end
            if (legalPush) begin
                stack[pushIdx] <= status;
                sp             <= sp + SPW'(1);
            end
            if ((push && !pop && stack_full) || (pop && !push && stack_empty)) begin
                stack_err <= 1'b1;
            end
        end
    end

    generate
        if (PIPE != 0) begin : gPipe
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cond_pass <= '0;
                    out_valid <= '0;
                end else if (flush) begin
                    cond_pass <= '0;
                    out_valid <= '0;
                end else begin
                    cond_pass <= pass;
                    out_valid <= in_valid;
                end
            end
        end else begin : gComb
            assign cond_pass = pass & ~{LANES{flush}};
            assign out_valid = in_valid & ~{LANES{flush}};
        end
    endgenerate

endmodule
